// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Two-port arbiter in front of a single-port word RAM. Port 0
//                is the CPU data path, port 1 the loader/debug path. Sub-word
//                stores are done as read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int DEPTH        = 256,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // port 0 (CPU data)
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [3:0]  req0_be,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    // port 1 (loader / debug)
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [3:0]  req1_be,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    // RAM side
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] c_depth        = 32'(DEPTH);
    localparam logic [3:0]  c_starve_limit = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR       = 3'd2,
        ST_RMW_RD   = 3'd3,
        ST_RMW_WR   = 3'd4,
        ST_RSP_ONLY = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic [3:0]  r_starve_cnt;
    logic        r_id;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_err;

    logic        w_grant;
    logic        w_grant_id;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_oob;
    logic [31:0] w_merged;
    logic        w_rsp_fire;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_err;

    // Arbitration: only in IDLE, at most one winner, decided on current valids
    always_comb begin
        w_grant    = 1'b0;
        w_grant_id = 1'b0;
        if (r_state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant = 1'b1;
                if (FIXED_PRIO != 0) begin
                    w_grant_id = (r_starve_cnt == c_starve_limit);
                end else begin
                    w_grant_id = ~r_last_grant;
                end
            end else if (req0_valid) begin
                w_grant    = 1'b1;
                w_grant_id = 1'b0;
            end else if (req1_valid) begin
                w_grant    = 1'b1;
                w_grant_id = 1'b1;
            end
        end
    end

    assign req0_ready = w_grant & ~w_grant_id;
    assign req1_ready = w_grant &  w_grant_id;

    // Winner's request fields and the out-of-range decode
    always_comb begin
        w_we    = w_grant_id ? req1_we    : req0_we;
        w_be    = w_grant_id ? req1_be    : req0_be;
        w_addr  = w_grant_id ? req1_addr  : req0_addr;
        w_wdata = w_grant_id ? req1_wdata : req0_wdata;
        w_oob   = ({2'b00, w_addr[31:2]} >= c_depth);
    end

    // Byte merge of the stored word with the enabled write bytes
    always_comb begin
        w_merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    // Response content for the state that completes this cycle
    always_comb begin
        w_rsp_fire  = (r_state == ST_RD) || (r_state == ST_WR) ||
                      (r_state == ST_RMW_WR) || (r_state == ST_RSP_ONLY);
        w_rsp_rdata = (r_state == ST_RD) ? mem_rdata : 32'h0;
        w_rsp_err   = (r_state == ST_RSP_ONLY) ? r_err : 1'b0;
    end

    // Main sequencer: state, latched request, RAM strobes and responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_starve_cnt <= 4'd0;
            r_id         <= 1'b0;
            r_be         <= 4'h0;
            r_wdata      <= 32'h0;
            r_err        <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp0_rdata   <= 32'h0;
            rsp0_err     <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_rdata   <= 32'h0;
            rsp1_err     <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_id         <= w_grant_id;
                        r_be         <= w_be;
                        r_wdata      <= w_wdata;
                        r_err        <= w_oob;
                        r_last_grant <= w_grant_id;
                        if (FIXED_PRIO != 0) begin
                            if (w_grant_id) begin
                                r_starve_cnt <= 4'd0;
                            end else if (req1_valid) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end
                        if (w_oob || (w_we && (w_be == 4'h0))) begin
                            r_state <= ST_RSP_ONLY;
                        end else if (!w_we) begin
                            r_state  <= ST_RD;
                            mem_read <= 1'b1;
                            mem_addr <= w_addr;
                        end else if (w_be == 4'hF) begin
                            r_state   <= ST_WR;
                            mem_write <= 1'b1;
                            mem_addr  <= w_addr;
                            mem_wdata <= w_wdata;
                        end else begin
                            r_state  <= ST_RMW_RD;
                            mem_read <= 1'b1;
                            mem_addr <= w_addr;
                        end
                    end
                end
                ST_RMW_RD: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_wdata <= w_merged;
                    r_state   <= ST_RMW_WR;
                end
                ST_RD: begin
                    mem_read <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                ST_WR, ST_RMW_WR: begin
                    mem_write <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase

            if (w_rsp_fire) begin
                if (r_id) begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= w_rsp_rdata;
                    rsp1_err   <= w_rsp_err;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= w_rsp_rdata;
                    rsp0_err   <= w_rsp_err;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Self-checking bench for ram_port_arbiter. Instance A runs
//                round-robin, instance B fixed priority with starvation guard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance A (round-robin)
    logic        a_req0_valid, a_req0_we, a_req0_ready, a_rsp0_valid, a_rsp0_err;
    logic [3:0]  a_req0_be;
    logic [31:0] a_req0_addr, a_req0_wdata, a_rsp0_rdata;
    logic        a_req1_valid, a_req1_we, a_req1_ready, a_rsp1_valid, a_rsp1_err;
    logic [3:0]  a_req1_be;
    logic [31:0] a_req1_addr, a_req1_wdata, a_rsp1_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_read, a_mem_write;

    // instance B (fixed priority)
    logic        b_req0_valid, b_req0_ready, b_rsp0_valid, b_rsp0_err;
    logic        b_req1_valid, b_req1_ready, b_rsp1_valid, b_rsp1_err;
    logic [31:0] b_rsp0_rdata, b_rsp1_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_read, b_mem_write;

    // RAM models: combinational read, negedge write
    logic [31:0] ram_a [256];
    logic [31:0] ram_b [256];
    logic [31:0] ref_mem [256];
    logic        load;

    always @(negedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) begin
                ram_a[i] <= ref_mem[i];
                ram_b[i] <= ref_mem[i];
            end
        end else begin
            if (a_mem_write) ram_a[a_mem_addr[9:2]] <= a_mem_wdata;
            if (b_mem_write) ram_b[b_mem_addr[9:2]] <= b_mem_wdata;
        end
    end
    assign a_mem_rdata = ram_a[a_mem_addr[9:2]];
    assign b_mem_rdata = ram_b[b_mem_addr[9:2]];

    ram_port_arbiter #(.DEPTH(256), .FIXED_PRIO(0), .STARVE_LIMIT(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_req0_valid), .req0_we(a_req0_we), .req0_be(a_req0_be),
        .req0_addr(a_req0_addr), .req0_wdata(a_req0_wdata), .req0_ready(a_req0_ready),
        .rsp0_valid(a_rsp0_valid), .rsp0_rdata(a_rsp0_rdata), .rsp0_err(a_rsp0_err),
        .req1_valid(a_req1_valid), .req1_we(a_req1_we), .req1_be(a_req1_be),
        .req1_addr(a_req1_addr), .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready),
        .rsp1_valid(a_rsp1_valid), .rsp1_rdata(a_rsp1_rdata), .rsp1_err(a_rsp1_err),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .mem_rdata(a_mem_rdata)
    );

    ram_port_arbiter #(.DEPTH(256), .FIXED_PRIO(1), .STARVE_LIMIT(4)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_we(1'b0), .req0_be(4'hF),
        .req0_addr(32'h0000_0000), .req0_wdata(32'h0), .req0_ready(b_req0_ready),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata), .rsp0_err(b_rsp0_err),
        .req1_valid(b_req1_valid), .req1_we(1'b0), .req1_be(4'hF),
        .req1_addr(32'h0000_0004), .req1_wdata(32'h0), .req1_ready(b_req1_ready),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata), .rsp1_err(b_rsp1_err),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_rdata(b_mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (nw & m) | (old & ~m);
    endfunction

    task automatic drive(input int p, input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            a_req0_valid = v; a_req0_we = we; a_req0_be = be;
            a_req0_addr = addr; a_req0_wdata = wd;
        end else begin
            a_req1_valid = v; a_req1_we = we; a_req1_be = be;
            a_req1_addr = addr; a_req1_wdata = wd;
        end
    endtask

    function automatic logic a_rdy(input int p);
        return (p == 0) ? a_req0_ready : a_req1_ready;
    endfunction
    function automatic logic a_rspv(input int p);
        return (p == 0) ? a_rsp0_valid : a_rsp1_valid;
    endfunction
    function automatic logic [31:0] a_rdata(input int p);
        return (p == 0) ? a_rsp0_rdata : a_rsp1_rdata;
    endfunction
    function automatic logic a_err(input int p);
        return (p == 0) ? a_rsp0_err : a_rsp1_err;
    endfunction

    // One request on instance A, called at posedge+1 or later in an idle cycle;
    // returns at posedge+2 of the response cycle.
    task automatic xact(input int p, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
        int          waitc;
        int          lat;
        int          exp_lat;
        logic        oob;
        logic        noacc;
        logic        partial;
        logic        full;
        logic [7:0]  idx;
        logic [31:0] merged;
        logic [31:0] exp_rdata;
        idx       = addr[9:2];
        oob       = (addr[31:10] != 22'd0);
        noacc     = oob || (we && be == 4'h0);
        full      = !oob && we && be == 4'hF;
        partial   = !noacc && we && !full;
        exp_lat   = partial ? 3 : 2;
        merged    = merge(ref_mem[idx], wd, be);
        exp_rdata = (oob || we) ? 32'h0 : ref_mem[idx];

        drive(p, 1'b1, we, be, addr, wd);
        #1;
        waitc = 0;
        while (a_rdy(p) !== 1'b1 && waitc < 20) begin
            @(posedge clk); #2;
            waitc++;
        end
        check("accept_in_time", 32'(waitc < 20), 32'd1);
        check("other_not_ready", 32'(a_rdy(1 - p)), 32'd0);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        check("t1_mem_read", 32'(a_mem_read), 32'(!noacc && !full));
        check("t1_mem_write", 32'(a_mem_write), 32'(full));
        if (!noacc) check("t1_mem_addr", 32'(a_mem_addr[31:2]), 32'(addr[31:2]));
        if (full) check("t1_mem_wdata", a_mem_wdata, wd);
        lat = 1;
        while (a_rspv(p) !== 1'b1 && lat < 6) begin
            @(posedge clk); #2;
            lat++;
            if (lat == 2 && partial) begin
                check("rmw_write", 32'(a_mem_write), 32'd1);
                check("rmw_no_read", 32'(a_mem_read), 32'd0);
                check("rmw_wdata", a_mem_wdata, merged);
            end
        end
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_rdata", a_rdata(p), exp_rdata);
        check("rsp_err", 32'(a_err(p)), 32'(oob));
        if (!oob && we) ref_mem[idx] = merged;
    endtask

    initial begin
        int          a_n, b_n, a_lastc;
        int          p;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;

        rst_n = 1'b0;
        load  = 1'b1;
        b_req0_valid = 1'b0;
        b_req1_valid = 1'b0;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[5] = 32'hDEADBEEF;
        ref_mem[8] = 32'h11223344;
        repeat (3) @(posedge clk);
        #2;

        // reset values
        check("rst_mem_read", 32'(a_mem_read), 32'd0);
        check("rst_mem_write", 32'(a_mem_write), 32'd0);
        check("rst_mem_addr", a_mem_addr, 32'h0);
        check("rst_mem_wdata", a_mem_wdata, 32'h0);
        check("rst_rsp0", {a_rsp0_valid, a_rsp0_err, a_rsp0_rdata[29:0]}, 32'h0);
        check("rst_rsp1", {a_rsp1_valid, a_rsp1_err, a_rsp1_rdata[29:0]}, 32'h0);
        check("rst_b_mem", {b_mem_read, b_mem_write, b_mem_addr[29:0]}, 32'h0);

        @(posedge clk); #1;
        load  = 1'b0;
        rst_n = 1'b1;

        // directed: read, partial write, readback, error read, zero-be write
        xact(0, 1'b0, 4'hF, 32'h0000_0014, 32'h0);
        xact(1, 1'b1, 4'b0100, 32'h0000_0020, 32'h00AB_0000);
        check("rmw_ram_value", ram_a[8], 32'h11AB3344);
        xact(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        xact(0, 1'b0, 4'hF, 32'h0000_0400, 32'h0);
        xact(1, 1'b1, 4'h0, 32'h0000_0030, 32'hCAFE_F00D);
        xact(1, 1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D);

        // randomized single requests against the reference memory
        for (int k = 0; k < 40; k++) begin
            p  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom);
            wd = $urandom;
            if ($urandom_range(0, 7) == 0) addr = {20'($urandom_range(1, 4095)), 12'($urandom)};
            else                           addr = {22'd0, 10'($urandom)};
            xact(p, we, be, addr, wd);
        end

        // reset asserted during the write phase of a read-modify-write
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 4'b0010, 32'h0000_0040, 32'h0000_5500);
        #1;
        check("rst_case_ready", 32'(a_req0_ready), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #2;
        check("rst_case_write_on", 32'(a_mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_case_write_off", 32'(a_mem_write), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            check("rst_case_no_rsp", 32'({a_rsp0_valid, a_rsp1_valid}), 32'd0);
        end
        check("rst_case_ram_kept", ram_a[16], ref_mem[16]);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xact(0, 1'b0, 4'hF, 32'h0000_0040, 32'h0);

        // continuous contention on both instances after a fresh reset
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h0000_0024, 32'h0);
        b_req0_valid = 1'b1;
        b_req1_valid = 1'b1;
        #1;
        a_n = 0;
        b_n = 0;
        a_lastc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            check("rr_both_ready", 32'(a_req0_ready & a_req1_ready), 32'd0);
            check("fp_both_ready", 32'(b_req0_ready & b_req1_ready), 32'd0);
            check("rw_exclusive", 32'(a_mem_read & a_mem_write), 32'd0);
            if (a_req0_ready || a_req1_ready) begin
                check("rr_order", 32'(a_req1_ready), 32'(a_n % 2));
                if (a_n > 0) check("rr_gap", 32'(cyc - a_lastc), 32'd2);
                a_lastc = cyc;
                a_n++;
            end
            if (b_req0_ready || b_req1_ready) begin
                check("fp_order", 32'(b_req1_ready), 32'(b_n % 5 == 4));
                b_n++;
            end
            @(posedge clk); #2;
        end
        check("rr_grant_count", 32'(a_n), 32'd20);
        check("fp_grant_count", 32'(b_n), 32'd20);
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        b_req0_valid = 1'b0;
        b_req1_valid = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
